// File: rtl/proc_pkg.sv
// Shared processor types and constants for the fetch front end.
package proc_pkg;

    localparam int XLEN           = 32;
    localparam int INSTR_W        = 32;
    localparam int PC_STEP        = 4;
    localparam int IMEM_IDX_SHIFT = 2;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction fetches are word-granular, so the low byte-offset bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~((XLEN'(1) << IMEM_IDX_SHIFT) - XLEN'(1));
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch-to-decode handshake bundle; the fetch side is the master.
interface fetch_queue_stage_if;
    import proc_pkg::*;

    logic               id_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] id_instr;
    logic [XLEN-1:0]    id_pc;

    modport master (
        output id_valid,
        output id_instr,
        output id_pc,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  id_pc,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with synchronous push/pop/flush and a registered head slot.
module fetch_fifo
    import proc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] next_rd;
    logic [CNT_W-1:0] next_count;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        next_rd    = rd_ptr + PTR_W'(pop_ok);
        next_count = count;
        if (push_ok && !pop_ok) begin
            next_count = count + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            next_count = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // The head register is loaded with whatever will sit at the read pointer
    // next cycle, bypassing the array when that slot is being written now.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= next_rd;
            count  <= next_count;
            if (next_count == '0) begin
                head <= '0;
            end else if (push_ok && (wr_ptr == next_rd)) begin
                head <= wdata;
            end else begin
                head <= mem[next_rd];
            end
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction fetch front end: PC, prefetch queue and decode handshake.
// Optional fetch/stall counters are enabled with the FETCH_STATS_EN macro.
module fetch_queue_stage
    import proc_pkg::*;
#(
    parameter  int              DEPTH    = 4,
    parameter  logic [XLEN-1:0] PC_RESET = 32'h0000_0000,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    output logic [XLEN-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    fetch_queue_stage_if.master id,
    output logic [CNT_W-1:0]   q_count
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_stall
`endif
);

    logic [XLEN-1:0] fetch_pc;
    logic            full;
    logic            pop;
    logic            push;
    fetch_entry_t    wdata;
    fetch_entry_t    head;

    assign imem_pc     = fetch_pc;
    assign id.id_valid = (q_count != '0);
    assign id.id_instr = head.instr;
    assign id.id_pc    = head.pc;
    assign pop         = id.id_valid & id.id_ready;
    // A redirect cycle never fetches: the old fetch_pc belongs to the dead path.
    assign push        = (~full | pop) & ~redirect_valid;
    assign wdata       = '{pc: fetch_pc, instr: imem_instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= PC_RESET;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .count (q_count),
        .full  (full)
    );

`ifdef FETCH_STATS_EN
    // Counters saturate rather than wrap and survive redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push && (stat_fetched != 32'hFFFF_FFFF)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (full && !pop && (stat_stall != 32'hFFFF_FFFF)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the decode stage (IF_ID boundary) in the pipelined processor.
- Owns the PC and drives the byte address to the combinational instruction memory (word index = pc >> 2).
- Buffers fetched {pc, instruction} pairs in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports a redirect input for branch/jump targets, which flushes the queue.

Parameters:
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_pc  out  32  byte address to instruction memory; equals fetch_pc.
- imem_instr  in  32  instruction word, valid in the same cycle as imem_pc.
- redirect_valid  in  1  one-cycle pulse; load redirect_pc and flush the queue.
- redirect_pc  in  32  redirect target (byte address).
- id_valid  out  1  head entry is valid for decode.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_instr  out  32  head instruction.
- id_pc  out  32  PC of the head instruction.
- q_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (sync, highest priority): fetch_pc <= PC_RESET; FIFO empty; q_count=0; id_valid=0; id_instr=0; id_pc=0. Reset asserted mid-stream discards all entries.
- Outputs: id_valid = (q_count != 0). id_instr and id_pc come from the registered head slot; they read 0 when empty.
- pop = id_valid & id_ready.
- push = !full | pop, where full = (q_count == DEPTH).
  - On push: write {fetch_pc, imem_instr} at the tail and set fetch_pc <= fetch_pc + 4.
  - Full with a pop in the same cycle: push still occurs, q_count stays DEPTH.
  - Otherwise full: fetch_pc holds and imem_pc is stable.
- Empty: push only. An entry becomes visible on id_* one cycle after it is fetched.
  - Latency: fetch -> id_valid is 1 cycle.
  - Back-to-back throughput: 1 instruction per cycle.
- Redirect (priority below reset): FIFO flushed (q_count <= 0), fetch_pc <= {redirect_pc[31:2], 2'b00}, no push that cycle.
  - A pop handshake in the redirect cycle is considered completed by decode; all other entries are discarded.
  - Next cycle: id_valid=0 and the target is fetched. The cycle after that: id_pc = aligned target.
- Arithmetic: fetch_pc wraps modulo 2^32. Read/write pointers are log2(DEPTH) bits and wrap naturally.
- Misaligned PC_RESET is not supported; redirect targets are force-aligned as above.
- Invariant: q_count never exceeds DEPTH and never underflows; no pop occurs when empty.

Optional Feature:
- Macro FETCH_STATS_EN.
- Defined: adds output ports stat_fetched (32) and stat_stall (32).
  - stat_fetched increments on every push.
  - stat_stall increments on every cycle with full & !pop.
  - Both clear on reset, saturate at 32'hFFFF_FFFF, and do not clear on redirect.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package proc_pkg:
  - XLEN=32, INSTR_W=32, PC_STEP=4.
  - fetch_entry_t typedef {pc, instr}.
  - Memory word-index shift constant (2).
- Sub-module fetch_fifo: parameterised DEPTH, synchronous push/pop/flush, count output, head data registered. The top level holds the PC, push/pop/redirect logic and the stats counters.

Test Plan:
1. Reset 2 cycles, then id_ready=1 continuously:
   - id_valid rises 1 cycle after reset deasserts.
   - id_pc = 0,4,8,12,... on consecutive cycles; id_instr = memory[0],[1],...
2. id_ready=0 for 10 cycles after reset:
   - q_count saturates at 4 and imem_pc holds at 16.
   - id_pc holds at 0.
   - On release: id_pc = 0,4,8,12,16 with no bubbles.
3. Queue holds 3 entries, redirect_valid with redirect_pc=0x20:
   - Next cycle q_count=0, id_valid=0.
   - Following cycle id_valid=1, id_pc=0x20, id_instr=memory[8].
4. redirect_pc=0x23:
   - imem_pc=0x20; first delivered id_pc=0x20.
5. Full queue with id_ready=1 for one cycle:
   - q_count stays 4 and one new entry is pushed (imem_pc advances by 4).
   - Repeat with reset asserted for 1 cycle mid-stream: id_valid=0 next cycle, fetch restarts at 0x0.
6. With FETCH_STATS_EN, run scenario 2:
   - stat_stall counts the full & !pop cycles (6).
   - stat_fetched equals total pushes.
   - Reset clears both counters to 0.
